// File: rtl/bist_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bist_seq_ctrl
//
// Logic-BIST sequencer for multi-chain scan designs. An LFSR test-pattern
// generator supplies scan-in data to N_CHAINS chains. The sequencer runs
// N_PATTERNS shift/capture rounds of CHAIN_LEN shift cycles each, then performs
// one more CHAIN_LEN-cycle unload. Scan-out responses are compacted in a MISR.
// The final signature is compared against GOLDEN_SIG to produce a pass/fail
// verdict.
//
// Parameter constraints: LFSR_W >= N_CHAINS, MISR_W >= N_CHAINS, and
// LFSR_SEED must be nonzero.
//
// Ports
//   CK          in   clock; every state update happens on the rising edge
//   BIST_reset  in   asynchronous, active-high reset
//   bist_start  in   start request; honoured only in IDLE or DONE
//   so_in       in   [N_CHAINS] scan-out bits from the chains
//   scan_en     out  scan-shift enable (high in SHIFT and UNLOAD)
//   tpg_out     out  [N_CHAINS] scan-in data = lfsr[N_CHAINS-1:0]
//   bist_busy   out  high in SHIFT, CAPTURE, UNLOAD and COMPARE
//   bist_done   out  high in DONE
//   bist_pass   out  verdict; valid while bist_done = 1
//   signature   out  [MISR_W] current MISR contents
//   pattern_cnt out  [$clog2(N_PATTERNS+1)] number of patterns captured
// -----------------------------------------------------------------------------
module bist_seq_ctrl #(
    parameter int                N_CHAINS   = 7,
    parameter int                CHAIN_LEN  = 33,
    parameter int                N_PATTERNS = 100,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'h0001,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_TAPS  = 16'hB400,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic                              CK,
    input  logic                              BIST_reset,
    input  logic                              bist_start,
    input  logic [N_CHAINS-1:0]               so_in,
    output logic                              scan_en,
    output logic [N_CHAINS-1:0]               tpg_out,
    output logic                              bist_busy,
    output logic                              bist_done,
    output logic                              bist_pass,
    output logic [MISR_W-1:0]                 signature,
    output logic [$clog2(N_PATTERNS+1)-1:0]   pattern_cnt
);

    localparam int CNT_W = $clog2(N_PATTERNS + 1);
    localparam int SH_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [LFSR_W-1:0]   r_lfsr;
    logic [MISR_W-1:0]   r_misr;
    logic [CNT_W-1:0]    r_pattern_cnt;
    logic [SH_W-1:0]     r_shift_cnt;
    logic                r_pass;
    logic                r_first;    // set while the first pattern is shifted in

    logic                w_start_run;
    logic                w_shifting;
    logic                w_misr_step;
    logic                w_capture;
    logic                w_set_pass;
    logic                w_last_shift;

    logic                w_lfsr_fb;
    logic [LFSR_W-1:0]   w_lfsr_nxt;
    logic                w_misr_fb;
    logic [MISR_W-1:0]   w_misr_nxt;

    // -------------------------------------------------------------------------
    // Next-value logic for the TPG and the compactor
    // -------------------------------------------------------------------------
    assign w_lfsr_fb  = ^(r_lfsr & LFSR_TAPS);
    assign w_lfsr_nxt = {r_lfsr[LFSR_W-2:0], w_lfsr_fb};

    assign w_misr_fb  = ^(r_misr & MISR_TAPS);
    assign w_misr_nxt = {r_misr[MISR_W-2:0], w_misr_fb} ^ MISR_W'(so_in);

    assign w_last_shift = (r_shift_cnt == SH_W'(CHAIN_LEN - 1));

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: registers are written with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order across blocks.
    always_ff @(posedge CK or posedge BIST_reset) begin
        if (BIST_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and datapath controls
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case statement,
    // so that no path leaves a signal unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        w_shifting  = 1'b0;
        w_misr_step = 1'b0;
        w_capture   = 1'b0;
        w_set_pass  = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bist_start) begin
                    w_start_run = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shifting = 1'b1;
                // The chains still hold power-up garbage while the first
                // pattern goes in, so those responses are not compacted.
                w_misr_step = ~r_first;
                if (w_last_shift) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_capture = 1'b1;
                // Compare against N_PATTERNS-1: the count is incremented on
                // this same edge.
                if (r_pattern_cnt == CNT_W'(N_PATTERNS - 1)) begin
                    w_state_nxt = S_UNLOAD;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_UNLOAD: begin
                w_shifting  = 1'b1;
                w_misr_step = 1'b1;
                if (w_last_shift) begin
                    w_state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_set_pass  = 1'b1;
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: TPG, MISR, counters and verdict
    // -------------------------------------------------------------------------
    always_ff @(posedge CK or posedge BIST_reset) begin
        if (BIST_reset) begin
            r_lfsr        <= LFSR_SEED;
            r_misr        <= '0;
            r_pattern_cnt <= '0;
            r_shift_cnt   <= '0;
            r_pass        <= 1'b0;
            r_first       <= 1'b0;
        end else if (w_start_run) begin
            r_lfsr        <= LFSR_SEED;
            r_misr        <= '0;
            r_pattern_cnt <= '0;
            r_shift_cnt   <= '0;
            r_pass        <= 1'b0;
            r_first       <= 1'b1;
        end else begin
            if (w_shifting) begin
                // The LFSR also runs through UNLOAD; its content is unused there.
                r_lfsr      <= w_lfsr_nxt;
                r_shift_cnt <= w_last_shift ? '0 : r_shift_cnt + 1'b1;
            end
            if (w_misr_step) begin
                r_misr <= w_misr_nxt;
            end
            if (w_capture) begin
                r_pattern_cnt <= r_pattern_cnt + 1'b1;
                r_first       <= 1'b0;
            end
            if (w_set_pass) begin
                r_pass <= (r_misr == GOLDEN_SIG);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: registers or decodes of the registered state only
    // -------------------------------------------------------------------------
    assign scan_en     = (r_state == S_SHIFT) || (r_state == S_UNLOAD);
    assign bist_busy   = (r_state == S_SHIFT) || (r_state == S_CAPTURE) ||
                         (r_state == S_UNLOAD) || (r_state == S_COMPARE);
    assign bist_done   = (r_state == S_DONE);
    assign bist_pass   = r_pass;
    assign tpg_out     = r_lfsr[N_CHAINS-1:0];
    assign signature   = r_misr;
    assign pattern_cnt = r_pattern_cnt;

endmodule
